// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: shares one memory port between an I-cache (port 0, line reads
// only) and a D-cache (port 1, line reads or single-word stores). One transaction
// is in flight at a time: a command beat, then either a read burst forwarded
// straight to the requester or a store-data beat followed by a one-cycle ack.
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants between the ports
// when both request together; without it port 1 always wins a tie.
module l1_mem_arbiter #(
    parameter int WORDS_PER_LINE = 8,
    parameter int OFFSET_BITS    = 5
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        p0_req_valid,
    input  logic [31:0] p0_req_addr,
    output logic        p0_req_ready,
    output logic        p0_rsp_valid,
    input  logic        p1_req_valid,
    input  logic [31:0] p1_req_addr,
    input  logic        p1_req_write,
    input  logic [31:0] p1_req_wdata,
    output logic        p1_req_ready,
    output logic        p1_rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int BEAT_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
    localparam logic [31:0] LINE_MASK = ~((32'h1 << OFFSET_BITS) - 32'h1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RBURST,
        WDATA,
        WACK
    } state_e;

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              grant_q, grant_d;
    logic              write_q, write_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              accept;
    logic              grant_sel;

`ifdef ARB_ROUND_ROBIN_EN
    logic              last_grant_q, last_grant_d;
`endif

    // Arbitration: pick the winning port in IDLE; no grant while reset is held
    always_comb begin
        accept    = 1'b0;
        grant_sel = 1'b0;
        if (RST_N && (state_q == IDLE) && (p0_req_valid || p1_req_valid)) begin
            accept = 1'b1;
            if (p0_req_valid && p1_req_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
                grant_sel = ~last_grant_q;
`else
                grant_sel = 1'b1;
`endif
            end else begin
                grant_sel = p1_req_valid;
            end
        end
    end

    // Next-state logic: walk one transaction through command, data and response
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        grant_d = grant_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CMD;
                    beat_d  = '0;
                    grant_d = grant_sel;
                    write_d = grant_sel & p1_req_write;
                    addr_d  = grant_sel ? p1_req_addr : p0_req_addr;
                    wdata_d = grant_sel ? p1_req_wdata : 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = grant_sel;
`endif
                end
            end
            CMD: begin
                if (mem_ready) begin
                    state_d = write_q ? WDATA : RBURST;
                end
            end
            RBURST: begin
                if (mem_rvalid) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            WDATA: begin
                if (mem_ready) begin
                    state_d = WACK;
                end
            end
            WACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: everything is a function of the current state and live inputs
    always_comb begin
        p0_req_ready = 1'b0;
        p1_req_ready = 1'b0;
        p0_rsp_valid = 1'b0;
        p1_rsp_valid = 1'b0;
        rsp_data     = 32'h0;
        rsp_last     = 1'b0;
        mem_valid    = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        case (state_q)
            IDLE: begin
                p0_req_ready = accept & ~grant_sel;
                p1_req_ready = accept & grant_sel;
            end
            CMD: begin
                mem_valid = 1'b1;
                mem_write = write_q;
                mem_addr  = write_q ? addr_q : (addr_q & LINE_MASK);
            end
            RBURST: begin
                if (mem_rvalid) begin
                    rsp_data     = mem_rdata;
                    p0_rsp_valid = ~grant_q;
                    p1_rsp_valid = grant_q;
                    rsp_last     = (beat_q == LAST_BEAT);
                end
            end
            WDATA: begin
                mem_valid = 1'b1;
                mem_write = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            WACK: begin
                p1_rsp_valid = 1'b1;
                rsp_last     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State and latched-request registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            beat_q  <= '0;
            grant_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            grant_q <= grant_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb_l1_mem_arbiter: directed stimulus for l1_mem_arbiter with a transaction-level
// reference model that predicts every output on every cycle, plus literal checks
// on addresses, beat counts, grant order and latency for each scenario.
module tb_l1_mem_arbiter;

    localparam int W  = 8;
    localparam int OB = 5;

`ifdef ARB_ROUND_ROBIN_EN
    localparam int FIRST_EXP = 0;
`else
    localparam int FIRST_EXP = 1;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        p0_req_valid = 1'b0;
    logic [31:0] p0_req_addr = 32'h0;
    logic        p0_req_ready;
    logic        p0_rsp_valid;
    logic        p1_req_valid = 1'b0;
    logic [31:0] p1_req_addr = 32'h0;
    logic        p1_req_write = 1'b0;
    logic [31:0] p1_req_wdata = 32'h0;
    logic        p1_req_ready;
    logic        p1_rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    l1_mem_arbiter #(.WORDS_PER_LINE(W), .OFFSET_BITS(OB)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .p0_req_valid(p0_req_valid), .p0_req_addr(p0_req_addr),
        .p0_req_ready(p0_req_ready), .p0_rsp_valid(p0_rsp_valid),
        .p1_req_valid(p1_req_valid), .p1_req_addr(p1_req_addr),
        .p1_req_write(p1_req_write), .p1_req_wdata(p1_req_wdata),
        .p1_req_ready(p1_req_ready), .p1_rsp_valid(p1_rsp_valid),
        .rsp_data(rsp_data), .rsp_last(rsp_last),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_checks = 0;
    int cyc = 0;
    bit checking = 1'b0;

    // Observations of the DUT used by the literal checks
    int          p0_beats = 0;
    int          p1_beats = 0;
    int          last_cnt = 0;
    int          accept_cyc = 0;
    int          last_cyc = 0;
    logic [31:0] last_data = 32'h0;
    logic [31:0] read_cmd_addr = 32'h0;
    logic [31:0] write_data_seen = 32'h0;

    // Reference model: the transaction currently in flight and its progress
    bit          m_active = 1'b0;
    int          m_port = 0;
    bit          m_write = 1'b0;
    bit          m_cmd_done = 1'b0;
    bit          m_data_done = 1'b0;
    int          m_beats = 0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    int          m_last_grant = 1;

    int          winner;
    logic        e_p0_ready, e_p1_ready, e_p0_rsp, e_p1_rsp, e_last, e_mvalid, e_mwrite;
    logic        e_chk_addr, e_chk_wdata;
    logic [31:0] e_maddr, e_mwdata, e_rdata;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     name, actual, expected, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Per-cycle compare against the model, then advance the model to the next edge
    always @(negedge CLK) begin
        winner = -1;
        if (RST_N) begin
            if (p0_req_valid && p1_req_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
                winner = (m_last_grant == 1) ? 0 : 1;
`else
                winner = 1;
`endif
            end else if (p0_req_valid) begin
                winner = 0;
            end else if (p1_req_valid) begin
                winner = 1;
            end
        end

        e_p0_ready = 1'b0; e_p1_ready = 1'b0; e_p0_rsp = 1'b0; e_p1_rsp = 1'b0;
        e_last = 1'b0; e_mvalid = 1'b0; e_mwrite = 1'b0;
        e_chk_addr = 1'b0; e_chk_wdata = 1'b0;
        e_maddr = 32'h0; e_mwdata = 32'h0; e_rdata = 32'h0;

        if (!m_active) begin
            e_p0_ready = (winner == 0);
            e_p1_ready = (winner == 1);
        end else if (!m_cmd_done) begin
            e_mvalid   = 1'b1;
            e_mwrite   = m_write;
            e_chk_addr = 1'b1;
            e_maddr    = m_write ? m_addr : (m_addr / (32'h1 << OB)) * (32'h1 << OB);
        end else if (!m_write) begin
            if (mem_rvalid) begin
                e_p0_rsp = (m_port == 0);
                e_p1_rsp = (m_port == 1);
                e_rdata  = mem_rdata;
                e_last   = (m_beats == W - 1);
            end
        end else if (!m_data_done) begin
            e_mvalid    = 1'b1;
            e_mwrite    = 1'b1;
            e_chk_wdata = 1'b1;
            e_mwdata    = m_wdata;
        end else begin
            e_p1_rsp = 1'b1;
            e_last   = 1'b1;
            e_rdata  = 32'h0;
        end

        if (checking) begin
            checkOutput("p0_req_ready", 32'(p0_req_ready), 32'(e_p0_ready));
            checkOutput("p1_req_ready", 32'(p1_req_ready), 32'(e_p1_ready));
            checkOutput("p0_rsp_valid", 32'(p0_rsp_valid), 32'(e_p0_rsp));
            checkOutput("p1_rsp_valid", 32'(p1_rsp_valid), 32'(e_p1_rsp));
            checkOutput("rsp_last", 32'(rsp_last), 32'(e_last));
            checkOutput("mem_valid", 32'(mem_valid), 32'(e_mvalid));
            if (e_mvalid) checkOutput("mem_write", 32'(mem_write), 32'(e_mwrite));
            if (e_chk_addr) checkOutput("mem_addr", mem_addr, e_maddr);
            if (e_chk_wdata) checkOutput("mem_wdata", mem_wdata, e_mwdata);
            if (e_p0_rsp || e_p1_rsp) checkOutput("rsp_data", rsp_data, e_rdata);

            if (p0_rsp_valid === 1'b1) p0_beats++;
            if (p1_rsp_valid === 1'b1) p1_beats++;
            if (rsp_last === 1'b1) begin
                last_cnt++;
                last_cyc  = cyc;
                last_data = rsp_data;
            end
            if (p0_req_ready === 1'b1 || p1_req_ready === 1'b1) accept_cyc = cyc;
            if (mem_valid === 1'b1 && mem_write === 1'b0) read_cmd_addr = mem_addr;
            if (mem_valid === 1'b1 && mem_write === 1'b1 && mem_ready) write_data_seen = mem_wdata;
        end

        if (!RST_N) begin
            m_active = 1'b0; m_beats = 0; m_last_grant = 1;
            m_addr = 32'h0; m_wdata = 32'h0; m_write = 1'b0;
        end else if (!m_active) begin
            if (winner >= 0) begin
                m_active    = 1'b1;
                m_port      = winner;
                m_write     = (winner == 1) ? p1_req_write : 1'b0;
                m_addr      = (winner == 1) ? p1_req_addr : p0_req_addr;
                m_wdata     = (winner == 1) ? p1_req_wdata : 32'h0;
                m_cmd_done  = 1'b0;
                m_data_done = 1'b0;
                m_beats     = 0;
                m_last_grant = winner;
            end
        end else if (!m_cmd_done) begin
            if (mem_ready) m_cmd_done = 1'b1;
        end else if (!m_write) begin
            if (mem_rvalid) begin
                m_beats++;
                if (m_beats == W) m_active = 1'b0;
            end
        end else if (!m_data_done) begin
            if (mem_ready) m_data_done = 1'b1;
        end else begin
            m_active = 1'b0;
        end
        cyc++;
    end

    // Drive the memory side for exactly one cycle
    task automatic applyStimulus(input logic mr, input logic rv, input logic [31:0] rd);
        mem_ready  = mr;
        mem_rvalid = rv;
        mem_rdata  = rd;
        @(posedge CLK);
        #1;
    endtask

    task automatic memIdle();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
    endtask

    task automatic doReset();
        RST_N = 1'b0;
        memIdle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checking = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        RST_N = 1'b1;
    endtask

    task automatic waitAccept(output int port);
        port = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (p0_req_ready === 1'b1) port = 0;
            else if (p1_req_ready === 1'b1) port = 1;
            @(posedge CLK);
            #1;
            if (port >= 0) break;
        end
        if (port < 0) checkOutput("accept_timeout", 32'h0, 32'h1);
    endtask

    // CMD handshake after optional stall, then the read burst (gap mode: 1,0,0,1,...)
    task automatic serveRead(input logic [31:0] base, input int stall, input bit gaps);
        int sent;
        int c;
        for (int i = 0; i < stall; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        sent = 0;
        c = 0;
        while (sent < W && c < 200) begin
            if (!gaps || (c % 3 == 0)) begin
                applyStimulus(1'b0, 1'b1, base + 32'(sent));
                sent++;
            end else begin
                applyStimulus(1'b0, 1'b0, 32'h0);
            end
            c++;
        end
        memIdle();
    endtask

    task automatic serveWrite(input int stall);
        for (int i = 0; i < stall; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        memIdle();
    endtask

    task automatic checkAllZero(input string tag);
        @(negedge CLK);
        checkOutput({tag, ".req_ready"}, 32'({p0_req_ready, p1_req_ready}), 32'h0);
        checkOutput({tag, ".rsp_valid"}, 32'({p0_rsp_valid, p1_rsp_valid}), 32'h0);
        checkOutput({tag, ".rsp_last"}, 32'(rsp_last), 32'h0);
        checkOutput({tag, ".mem_valid"}, 32'({mem_valid, mem_write}), 32'h0);
        checkOutput({tag, ".mem_addr"}, mem_addr, 32'h0);
        checkOutput({tag, ".mem_wdata"}, mem_wdata, 32'h0);
        checkOutput({tag, ".rsp_data"}, rsp_data, 32'h0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int port, first, second, b0, b1, lc;
        #1;
        doReset();
        checkAllZero("reset");

        // p0 line read with immediate ready and back-to-back beats
        b0 = p0_beats; b1 = p1_beats; lc = last_cnt;
        p0_req_valid = 1'b1; p0_req_addr = 32'h0000_1234;
        waitAccept(port);
        p0_req_valid = 1'b0;
        checkOutput("read.port", 32'(port), 32'h0);
        serveRead(32'hA0, 0, 1'b0);
        checkOutput("read.cmd_addr", read_cmd_addr, 32'h0000_1220);
        checkOutput("read.p0_beats", 32'(p0_beats - b0), 32'd8);
        checkOutput("read.p1_beats", 32'(p1_beats - b1), 32'd0);
        checkOutput("read.last_data", last_data, 32'hA7);
        checkOutput("read.last_count", 32'(last_cnt - lc), 32'd1);
        checkOutput("read.latency", 32'(last_cyc - accept_cyc), 32'(1 + W));

        // stray read data while idle must be ignored
        b0 = p0_beats; b1 = p1_beats;
        applyStimulus(1'b0, 1'b1, 32'h99);
        memIdle();
        checkOutput("idle_rvalid.beats", 32'((p0_beats - b0) + (p1_beats - b1)), 32'd0);

        // p1 store with memory stalling the command for three cycles
        b1 = p1_beats; lc = last_cnt;
        p1_req_valid = 1'b1; p1_req_write = 1'b1;
        p1_req_addr = 32'h0000_0040; p1_req_wdata = 32'hDEADBEEF;
        waitAccept(port);
        p1_req_valid = 1'b0; p1_req_write = 1'b0; p1_req_wdata = 32'h0;
        checkOutput("write.port", 32'(port), 32'h1);
        serveWrite(3);
        checkOutput("write.wdata", write_data_seen, 32'hDEADBEEF);
        checkOutput("write.ack_count", 32'(p1_beats - b1), 32'd1);
        checkOutput("write.last_count", 32'(last_cnt - lc), 32'd1);

        // read with gaps in the returned data
        b0 = p0_beats;
        p0_req_valid = 1'b1; p0_req_addr = 32'h0000_2010;
        waitAccept(port);
        p0_req_valid = 1'b0;
        serveRead(32'h10, 1, 1'b1);
        checkOutput("gaps.cmd_addr", read_cmd_addr, 32'h0000_2000);
        checkOutput("gaps.p0_beats", 32'(p0_beats - b0), 32'd8);
        checkOutput("gaps.last_data", last_data, 32'h17);

        // simultaneous requests straight out of reset
        doReset();
        p0_req_valid = 1'b1; p0_req_addr = 32'h0000_0100;
        p1_req_valid = 1'b1; p1_req_write = 1'b0; p1_req_addr = 32'h0000_0200;
        waitAccept(first);
        if (first == 0) p0_req_valid = 1'b0; else p1_req_valid = 1'b0;
        serveRead(32'h30, 0, 1'b0);
        waitAccept(second);
        p0_req_valid = 1'b0; p1_req_valid = 1'b0;
        serveRead(32'h40, 0, 1'b0);
        checkOutput("tie.first", 32'(first), 32'(FIRST_EXP));
        checkOutput("tie.second", 32'(second), 32'(1 - FIRST_EXP));
        checkOutput("tie.last_data", last_data, 32'h47);

        // p1 asks during a p0 burst and must wait for IDLE
        b1 = p1_beats;
        p0_req_valid = 1'b1; p0_req_addr = 32'h0000_3000;
        waitAccept(port);
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b1; p1_req_write = 1'b0; p1_req_addr = 32'h0000_4004;
        serveRead(32'h50, 0, 1'b0);
        waitAccept(port);
        p1_req_valid = 1'b0;
        checkOutput("held.port", 32'(port), 32'h1);
        checkOutput("held.accept_delay", 32'(accept_cyc - last_cyc), 32'd1);
        serveRead(32'h60, 0, 1'b0);
        checkOutput("held.cmd_addr", read_cmd_addr, 32'h0000_4000);
        checkOutput("held.p1_beats", 32'(p1_beats - b1), 32'd8);

        // reset in the middle of a burst, then a fresh p1 read
        b0 = p0_beats; lc = last_cnt;
        p0_req_valid = 1'b1; p0_req_addr = 32'h0000_5000;
        waitAccept(port);
        p0_req_valid = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 32'h70 + 32'(i));
        RST_N = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        RST_N = 1'b1;
        checkAllZero("midreset");
        checkOutput("midreset.p0_beats", 32'(p0_beats - b0), 32'd3);
        checkOutput("midreset.last_count", 32'(last_cnt - lc), 32'd0);
        b1 = p1_beats;
        p1_req_valid = 1'b1; p1_req_write = 1'b0; p1_req_addr = 32'h0000_6000;
        waitAccept(port);
        p1_req_valid = 1'b0;
        serveRead(32'h60, 0, 1'b0);
        checkOutput("after_reset.p1_beats", 32'(p1_beats - b1), 32'd8);
        checkOutput("after_reset.last_data", last_data, 32'h67);

        applyStimulus(1'b0, 1'b0, 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
